// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light controller: synchronizer depth and
// the channel map used to pack the asynchronous pin inputs.
package traffic_pkg;

  // Default synchronizer depth (flops per chain). Legal range is 2..4.
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Bit positions of each asynchronous input in the packed channel vector.
  localparam int CH_RESET    = 0;
  localparam int CH_SENSOR   = 1;
  localparam int CH_WR       = 2;
  localparam int CH_PROG     = 3;
  localparam int NUM_SYNC_CH = 4;

  typedef logic [NUM_SYNC_CH-1:0] sync_vec_t;

endpackage : traffic_pkg

// File: rtl/synchronizer_sync_cell.sv
// Single-bit multi-flop synchronizer chain with asynchronous active-low reset.
// The output comes straight from the last flop, so it is a clean level.
module sync_cell #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Depths outside 2..4 are rejected at elaboration.
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_cell: STAGES must be in 2..4");
  end

  // The attributes keep the tools from retiming, merging or packing these
  // flops into SRLs, which would defeat the metastability settling time.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; reset clears every stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : sync_cell

// File: rtl/synchronizer.sv
// Brings the four asynchronous pin inputs of the traffic-light controller
// (Reset button, Sensor, Walk_Request, Reprogram) into the clk domain.
// Each input gets its own independent chain; no edge detection or debouncing.
// The Reset input is ordinary data here and does not reset this block.
module synchronizer
  import traffic_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Reprogram,
  input  logic Walk_Request,
  input  logic Sensor,
  input  logic Reset,
  output logic Reset_Sync,
  output logic Sensor_Sync,
  output logic WR_Sync,
  output logic Prog_Sync
);

  sync_vec_t raw_vec;
  sync_vec_t sync_vec;

  // Pack the named pins into the channel vector.
  assign raw_vec[CH_RESET]  = Reset;
  assign raw_vec[CH_SENSOR] = Sensor;
  assign raw_vec[CH_WR]     = Walk_Request;
  assign raw_vec[CH_PROG]   = Reprogram;

  for (genvar ch = 0; ch < NUM_SYNC_CH; ch++) begin : g_chan
    sync_cell #(
      .STAGES   (SYNC_STAGES),
      .RESET_VAL(RESET_VAL)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (raw_vec[ch]),
      .q    (sync_vec[ch])
    );
  end

  // Unpack to the named outputs; pure wiring, nothing after the last flop.
  assign Reset_Sync  = sync_vec[CH_RESET];
  assign Sensor_Sync = sync_vec[CH_SENSOR];
  assign WR_Sync     = sync_vec[CH_WR];
  assign Prog_Sync   = sync_vec[CH_PROG];

endmodule : synchronizer

// File: tb/tb_synchronizer.sv
// Self-checking bench for the synchronizer (SYNC_STAGES = 2, clk period 6 ns).
module tb_synchronizer;

  logic clk;
  logic rst_n;
  logic Reprogram, Walk_Request, Sensor, Reset;
  logic Reset_Sync, Sensor_Sync, WR_Sync, Prog_Sync;

  int errors = 0;
  int checks = 0;

  // Bit order {Prog, WR, Sensor, Reset}
  logic [3:0] outs;
  assign outs = {Prog_Sync, WR_Sync, Sensor_Sync, Reset_Sync};

  synchronizer #(.SYNC_STAGES(2), .RESET_VAL(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Reprogram   (Reprogram),
    .Walk_Request(Walk_Request),
    .Sensor      (Sensor),
    .Reset       (Reset),
    .Reset_Sync  (Reset_Sync),
    .Sensor_Sync (Sensor_Sync),
    .WR_Sync     (WR_Sync),
    .Prog_Sync   (Prog_Sync)
  );

  // Rising edges at 3, 9, 15, ... ns
  initial clk = 1'b0;
  always #3 clk = ~clk;

  typedef struct {
    logic [3:0] in_v;
    logic [3:0] exp_v;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {Reprogram, Walk_Request, Sensor, Reset} = v;
  endtask

  task automatic idle(input int n);
    drive(4'b0000);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Expected output at entry i equals input driven two entries earlier.
    tbl[0] = '{4'b0001, 4'b0000};
    tbl[1] = '{4'b0010, 4'b0000};
    tbl[2] = '{4'b0100, 4'b0001};
    tbl[3] = '{4'b1000, 4'b0010};
    tbl[4] = '{4'b1111, 4'b0100};
    tbl[5] = '{4'b1010, 4'b1000};
    tbl[6] = '{4'b0101, 4'b1111};
    tbl[7] = '{4'b0000, 4'b1010};
    tbl[8] = '{4'b0000, 4'b0101};
    tbl[9] = '{4'b0000, 4'b0000};

    // Reset state
    rst_n = 1'b0;
    drive(4'b0000);
    repeat (3) @(negedge clk);
    check("reset_state", outs, 4'b0000);
    rst_n = 1'b1;
    idle(3);

    // Walk / Sensor latency and missed short pulse, timed from a rising edge T0
    @(posedge clk);
    #5  Walk_Request = 1'b1;             // T0+5
    #5  Walk_Request = 1'b0;             // T0+10, sampled by edge T0+6
    #1  check("wr_before", outs, 4'b0000);                   // T0+11
    #2  check("wr_high", outs, 4'b0100);                     // T0+13
        Sensor = 1'b1;
    #6  check("wr_fall", {3'b000, WR_Sync}, 4'b0000);        // T0+19
        Sensor = 1'b0;                   // only edge T0+18 saw Sensor
    #1  Reprogram = 1'b1;                // T0+20
    #2  Reprogram = 1'b0;                // T0+22, no edge in between
    #1  check("sensor_before", {3'b000, Sensor_Sync}, 4'b0000); // T0+23
    #2  check("sensor_high", outs, 4'b0010);                 // T0+25
    #6  check("sensor_fall", outs, 4'b0000);                 // T0+31
    #6  check("prog_missed", {3'b000, Prog_Sync}, 4'b0000);  // T0+37
    idle(3);

    // Table: per-cycle vectors including simultaneous changes on all inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("table_%0d", i), outs, tbl[i].exp_v);
      drive(tbl[i].in_v);
    end
    idle(3);

    // Asynchronous reset with all inputs high
    drive(4'b1111);
    repeat (3) @(negedge clk);
    check("all_high", outs, 4'b1111);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs, 4'b0000);                  // no edge yet
    #1 rst_n = 1'b1;
    #3 check("post_release_1edge", outs, 4'b0000);           // after 1st edge
    #6 check("post_release_2edge", outs, 4'b1111);           // after 2nd edge
    idle(3);

    // Reset mid-transfer on Sensor
    @(posedge clk);
    #1 Sensor = 1'b1;                    // T0+1, captured at T0+6
    #8 rst_n = 1'b0;                     // T0+9, before it reaches the output
    #1 check("mid_rst_a", outs, 4'b0000);                    // T0+10
    #3 check("mid_rst_b", outs, 4'b0000);                    // T0+13
    #6 check("mid_rst_c", outs, 4'b0000);                    // T0+19
    #1 rst_n = 1'b1;                     // T0+20
    #5 check("mid_rel_1edge", outs, 4'b0000);                // T0+25
    #6 check("mid_rel_2edge", outs, 4'b0010);                // T0+31
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_synchronizer
